// File: rtl/cpu_debug_ocimem_sequencer.sv
// Debug-memory access sequencer. It turns debug-slave command strobes into
// single-word reads and writes on the debug RAM port it shares with the CPU.
// The RAM port carries a 1-cycle we/re pulse in ISSUE, which is driven from
// state. Read data is captured RD_LAT cycles after ram_re.
// Valid/ready: a strobe is consumed only while monitor_ready is high (IDLE);
// a strobe seen while monitor_ready is low is dropped and flags monitor_error.
module cpu_debug_ocimem_sequencer #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              cpu_busy,
  input  logic [31:0]       ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [31:0]       mon_dreg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_PORT = 3'd1,
    S_ISSUE     = 3'd2,
    S_READ      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       dreg_q, dreg_d;
  logic              err_q, err_d;
  logic              is_rd_q, is_rd_d;
  logic              inc_q, inc_d;
  logic [1:0]        cnt_q, cnt_d;

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      dreg_q  <= '0;
      err_q   <= 1'b0;
      is_rd_q <= 1'b0;
      inc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dreg_q  <= dreg_d;
      err_q   <= err_d;
      is_rd_q <= is_rd_d;
      inc_q   <= inc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: strobe arbitration in IDLE, then port wait, issue, read latency.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dreg_d  = dreg_q;
    err_d   = err_q;
    is_rd_d = is_rd_q;
    inc_d   = inc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[ADDR_W+25:26];
          // A dropped lower-priority strobe in the same cycle still reports.
          err_d  = take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[35]) begin
            is_rd_d = 1'b1;
            inc_d   = 1'b0;
            state_d = cpu_busy ? S_WAIT_PORT : S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          is_rd_d = 1'b0;
          inc_d   = 1'b1;
          if (take_no_action_ocimem_a) err_d = 1'b1;
          state_d = cpu_busy ? S_WAIT_PORT : S_ISSUE;
        end else if (take_no_action_ocimem_a) begin
          is_rd_d = 1'b1;
          inc_d   = 1'b1;
          state_d = cpu_busy ? S_WAIT_PORT : S_ISSUE;
        end
      end
      S_WAIT_PORT: begin
        if (!cpu_busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (inc_q) addr_d = addr_q + ADDR_W'(1);
        cnt_d   = '0;
        state_d = is_rd_q ? S_READ : S_DONE;
      end
      S_READ: begin
        if (cnt_q == 2'(RD_LAT - 1)) begin
          dreg_d  = ram_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Any strobe arriving while busy is dropped without disturbing the access.
    if (state_q != S_IDLE &&
        (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a))
      err_d = 1'b1;
  end

  // Outputs: port enables decode ISSUE directly so they pulse for exactly that cycle.
  always_comb begin
    ram_addr      = addr_q;
    ram_wdata     = wdata_q;
    ram_we        = (state_q == S_ISSUE) && !is_rd_q;
    ram_re        = (state_q == S_ISSUE) && is_rd_q;
    mon_dreg      = dreg_q;
    monitor_ready = (state_q == S_IDLE);
    monitor_error = err_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_cpu_debug_ocimem_sequencer.sv
// Directed bench for cpu_debug_ocimem_sequencer with a behavioural debug RAM.
module tb_cpu_debug_ocimem_sequencer;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic              cpu_busy;
  logic [31:0]       ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we, ram_re;
  logic [31:0]       mon_dreg;
  logic              monitor_ready, monitor_error;
  logic [2:0]        dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Clock
  always #5 clk = ~clk;

  cpu_debug_ocimem_sequencer #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .cpu_busy(cpu_busy), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .mon_dreg(mon_dreg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .dbg_state(dbg_state)
  );

  // Behavioural RAM: unwritten words return a fixed pattern; read data is
  // valid only in the single cycle RD_LAT cycles after ram_re.
  logic [31:0]  wr_mem [256];
  logic [255:0] wr_valid = '0;
  logic [31:0]  d_pipe [RD_LAT];
  logic [RD_LAT-1:0] v_pipe = '0;

  function automatic logic [31:0] default_word(input logic [7:0] a);
    if (a == 8'h11) return 32'h12345678;
    if (a == 8'h20) return 32'h55AA55AA;
    return {24'hA5A5A5, a};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [7:0] a);
    return wr_valid[a] ? wr_mem[a] : default_word(a);
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      wr_mem[ram_addr]   <= ram_wdata;
      wr_valid[ram_addr] <= 1'b1;
    end
    d_pipe[0] <= mem_rd(ram_addr);
    v_pipe[0] <= ram_re;
    for (int i = 1; i < RD_LAT; i++) begin
      d_pipe[i] <= d_pipe[i-1];
      v_pipe[i] <= v_pipe[i-1];
    end
  end
  assign ram_rdata = v_pipe[RD_LAT-1] ? d_pipe[RD_LAT-1] : 32'hBAD0BAD0;

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    logic [37:0] j;
    j = '0;
    j[33:26] = addr;
    j[35] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] wd);
    logic [37:0] j;
    j = '0;
    j[34:3] = wd;
    return j;
  endfunction

  task automatic clear_strobes();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_busy = 1'b0; jdo = '0; clear_strobes();
    tick(); tick();
    reset = 1'b0;
    total_cnt++; if (ram_addr !== 8'h00) $display("FAIL reset_addr: got %0h exp 0", ram_addr); else pass_cnt++;
    total_cnt++; if (ram_wdata !== 32'h0) $display("FAIL reset_wdata: got %0h exp 0", ram_wdata); else pass_cnt++;
    total_cnt++; if ({ram_we, ram_re} !== 2'b00) $display("FAIL reset_we_re: got %b exp 00", {ram_we, ram_re}); else pass_cnt++;
    total_cnt++; if (mon_dreg !== 32'h0) $display("FAIL reset_dreg: got %0h exp 0", mon_dreg); else pass_cnt++;
    total_cnt++; if ({monitor_ready, monitor_error} !== 2'b10) $display("FAIL reset_status: got %b exp 10", {monitor_ready, monitor_error}); else pass_cnt++;
    total_cnt++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d exp 0", dbg_state); else pass_cnt++;
  endtask

  task automatic test_load();
    jdo = jdo_a(8'h10, 1'b0); take_action_ocimem_a = 1'b1;
    tick(); clear_strobes();
    total_cnt++; if (ram_addr !== 8'h10) $display("FAIL load_addr: got %0h exp 10", ram_addr); else pass_cnt++;
    total_cnt++; if ({monitor_ready, ram_we, ram_re} !== 3'b000) $display("FAIL load_t1: got %b exp 000", {monitor_ready, ram_we, ram_re}); else pass_cnt++;
    tick();
    total_cnt++; if ({monitor_ready, ram_we, ram_re} !== 3'b100) $display("FAIL load_t2: got %b exp 100", {monitor_ready, ram_we, ram_re}); else pass_cnt++;
  endtask

  task automatic test_write();
    jdo = jdo_b(32'hDEADBEEF); take_action_ocimem_b = 1'b1;
    tick(); clear_strobes();
    total_cnt++; if ({ram_we, ram_re} !== 2'b10) $display("FAIL write_we: got %b exp 10", {ram_we, ram_re}); else pass_cnt++;
    total_cnt++; if (ram_addr !== 8'h10) $display("FAIL write_addr: got %0h exp 10", ram_addr); else pass_cnt++;
    total_cnt++; if (ram_wdata !== 32'hDEADBEEF) $display("FAIL write_wdata: got %0h exp deadbeef", ram_wdata); else pass_cnt++;
    tick();
    total_cnt++; if ({ram_we, monitor_ready} !== 2'b00) $display("FAIL write_t2: got %b exp 00", {ram_we, monitor_ready}); else pass_cnt++;
    total_cnt++; if (ram_addr !== 8'h11) $display("FAIL write_inc: got %0h exp 11", ram_addr); else pass_cnt++;
    tick();
    total_cnt++; if (monitor_ready !== 1'b1) $display("FAIL write_ready: got %b exp 1", monitor_ready); else pass_cnt++;
  endtask

  task automatic test_read();
    take_no_action_ocimem_a = 1'b1;
    tick(); clear_strobes();
    total_cnt++; if ({ram_re, ram_we} !== 2'b10) $display("FAIL read_re: got %b exp 10", {ram_re, ram_we}); else pass_cnt++;
    total_cnt++; if (ram_addr !== 8'h11) $display("FAIL read_addr: got %0h exp 11", ram_addr); else pass_cnt++;
    tick();
    total_cnt++; if ({ram_re, ram_addr} !== {1'b0, 8'h12}) $display("FAIL read_inc: got %0h exp 012", {ram_re, ram_addr}); else pass_cnt++;
    tick();
    total_cnt++; if (mon_dreg !== 32'h0) $display("FAIL read_early: got %0h exp 0", mon_dreg); else pass_cnt++;
    tick();
    total_cnt++; if (mon_dreg !== 32'h12345678) $display("FAIL read_dreg: got %0h exp 12345678", mon_dreg); else pass_cnt++;
    total_cnt++; if (monitor_ready !== 1'b0) $display("FAIL read_ready_t4: got %b exp 0", monitor_ready); else pass_cnt++;
    tick();
    total_cnt++; if (monitor_ready !== 1'b1) $display("FAIL read_ready_t5: got %b exp 1", monitor_ready); else pass_cnt++;
  endtask

  task automatic test_load_read();
    jdo = jdo_a(8'h10, 1'b1); take_action_ocimem_a = 1'b1;
    tick(); clear_strobes();
    total_cnt++; if ({ram_re, ram_addr} !== {1'b1, 8'h10}) $display("FAIL lrd_re: got %0h exp 110", {ram_re, ram_addr}); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (mon_dreg !== 32'hDEADBEEF) $display("FAIL lrd_dreg: got %0h exp deadbeef", mon_dreg); else pass_cnt++;
    total_cnt++; if (ram_addr !== 8'h10) $display("FAIL lrd_noinc: got %0h exp 10", ram_addr); else pass_cnt++;
    tick();
  endtask

  task automatic test_wrap_busy();
    jdo = jdo_a(8'hFF, 1'b0); take_action_ocimem_a = 1'b1;
    tick(); clear_strobes(); tick();
    cpu_busy = 1'b1; jdo = jdo_b(32'hCAFEF00D); take_action_ocimem_b = 1'b1;
    tick(); clear_strobes();
    for (int i = 1; i <= 4; i++) begin
      total_cnt++; if (ram_we !== 1'b0) $display("FAIL busy_hold_%0d: got %b exp 0", i, ram_we); else pass_cnt++;
      tick();
    end
    cpu_busy = 1'b0;
    total_cnt++; if ({ram_we, dbg_state} !== {1'b0, 3'd1}) $display("FAIL busy_fall: got %0h exp 1", {ram_we, dbg_state}); else pass_cnt++;
    tick();
    total_cnt++; if ({ram_we, ram_addr} !== {1'b1, 8'hFF}) $display("FAIL busy_we: got %0h exp 1ff", {ram_we, ram_addr}); else pass_cnt++;
    tick();
    total_cnt++; if (ram_addr !== 8'h00) $display("FAIL wrap_addr: got %0h exp 0", ram_addr); else pass_cnt++;
    total_cnt++; if (mem_rd(8'hFF) !== 32'hCAFEF00D) $display("FAIL wrap_mem: got %0h exp cafef00d", mem_rd(8'hFF)); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    jdo = jdo_b(32'h0BADCAFE); take_action_ocimem_b = 1'b1; take_no_action_ocimem_a = 1'b1;
    tick(); clear_strobes();
    total_cnt++; if ({ram_we, ram_re, monitor_error} !== 3'b101) $display("FAIL dual_t1: got %b exp 101", {ram_we, ram_re, monitor_error}); else pass_cnt++;
    take_no_action_ocimem_a = 1'b1;
    tick(); clear_strobes();
    total_cnt++; if ({dbg_state, monitor_error} !== {3'd4, 1'b1}) $display("FAIL busy_strobe: got %0h exp 9", {dbg_state, monitor_error}); else pass_cnt++;
    tick();
    total_cnt++; if ({monitor_ready, ram_re, ram_addr} !== {2'b10, 8'h01}) $display("FAIL dual_done: got %0h exp 201", {monitor_ready, ram_re, ram_addr}); else pass_cnt++;
    total_cnt++; if (mem_rd(8'h00) !== 32'h0BADCAFE) $display("FAIL dual_mem: got %0h exp badcafe", mem_rd(8'h00)); else pass_cnt++;
    jdo = jdo_a(8'h20, 1'b0); take_action_ocimem_a = 1'b1;
    tick(); clear_strobes();
    total_cnt++; if (monitor_error !== 1'b0) $display("FAIL err_clear: got %b exp 0", monitor_error); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_read();
    reset = 1'b1; tick(); reset = 1'b0;
    jdo = jdo_a(8'h20, 1'b1); take_action_ocimem_a = 1'b1;
    tick(); clear_strobes();
    total_cnt++; if ({ram_re, ram_addr} !== {1'b1, 8'h20}) $display("FAIL rst_rd_re: got %0h exp 120", {ram_re, ram_addr}); else pass_cnt++;
    tick();
    total_cnt++; if (dbg_state !== 3'd3) $display("FAIL rst_rd_in_read: got %0d exp 3", dbg_state); else pass_cnt++;
    reset = 1'b1;
    tick(); reset = 1'b0;
    total_cnt++; if ({dbg_state, monitor_ready} !== {3'd0, 1'b1}) $display("FAIL rst_rd_idle: got %0h exp 1", {dbg_state, monitor_ready}); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (mon_dreg !== 32'h0) $display("FAIL rst_rd_dreg: got %0h exp 0", mon_dreg); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_write();
    test_read();
    test_load_read();
    test_wrap_busy();
    test_back_to_back();
    test_reset_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
